fp_add_normalize: RTL

//  Downstream neighbour of the FP adder Alignment stage. Takes the aligned 24-bit mantissas, signs
//  and common exponent, then adds or subtracts them. Normalizes the sum with a leading-zero shift,

---
 rtl/fp_add_normalize.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fp_add_normalize.sv
// rtl/fp_add_normalize.sv - FP adder add/sub, normalize and IEEE-754 pack stage
//
// Two-stage pipeline that follows the alignment stage of the FP adder.
// Stage 1 adds or subtracts the aligned mantissas and resolves Inf/NaN operands.
// Stage 2 normalizes the sum (leading-zero shift, truncation only) and packs the result.
//
// Ports
//   clk, rstN                 clock, synchronous active-low reset
//   inValid / inReady         input handshake
//   inSignA / inSignB         operand signs
//   inExponent                common exponent from alignment
//   inAlignedMantissaA/B      {hidden, mantissa} after alignment
//   outValid / outReady       output handshake
//   outResult                 packed {sign, exp, mantissa}
//   outOverflow               finite operands overflowed to Inf
module fp_add_normalize #(
    parameter int EXP_W = 8,
    parameter int MANT_W = 23,
    parameter logic [EXP_W+MANT_W:0] QNAN = 32'h7FC00000
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic                    inSignA,
    input  logic                    inSignB,
    input  logic [EXP_W-1:0]        inExponent,
    input  logic [MANT_W:0]         inAlignedMantissaA,
    input  logic [MANT_W:0]         inAlignedMantissaB,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [EXP_W+MANT_W:0]   outResult,
    output logic                    outOverflow
);

    localparam int LZ_W = $clog2(MANT_W + 2);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    // Leading-zero count of a nonzero MANT_W+1 bit value; the highest set bit wins.
    function automatic logic [LZ_W-1:0] lzc(input logic [MANT_W:0] v);
        lzc = LZ_W'(MANT_W + 1);
        for (int i = 0; i <= MANT_W; i++) begin
            if (v[i]) lzc = LZ_W'(MANT_W - i);
        end
    endfunction

    // Pipeline registers
    logic                   s1_valid_q, s2_valid_q;
    logic [MANT_W+1:0]      sum_q, sum_d;
    logic                   sign_q, sign_d;
    logic                   zero_neg_q;
    logic [EXP_W-1:0]       exp_q;
    logic                   special_q, is_nan_q, inf_sign_q;
    logic [EXP_W+MANT_W:0]  result_q, result_d;
    logic                   ovf_q, ovf_d;

    logic s2_advance, s1_advance;
    assign s2_advance = !s2_valid_q || outReady;
    assign s1_advance = !s1_valid_q || s2_advance;
    assign inReady    = s1_advance;
    assign outValid   = s2_valid_q;
    assign outResult  = result_q;
    assign outOverflow = ovf_q;

    // Stage 1: special-operand detection. A cleared hidden bit with an all-ones
    // exponent marks the operand as Inf (zero mantissa) or NaN (nonzero mantissa).
    logic spec_a, spec_b, nan_a, nan_b, inf_a, inf_b, is_nan_d, inf_sign_d;
    always_comb begin
        spec_a     = (inExponent == EXP_ONES) && !inAlignedMantissaA[MANT_W];
        spec_b     = (inExponent == EXP_ONES) && !inAlignedMantissaB[MANT_W];
        nan_a      = spec_a && (inAlignedMantissaA[MANT_W-1:0] != '0);
        nan_b      = spec_b && (inAlignedMantissaB[MANT_W-1:0] != '0);
        inf_a      = spec_a && !nan_a;
        inf_b      = spec_b && !nan_b;
        is_nan_d   = nan_a || nan_b || (inf_a && inf_b && (inSignA != inSignB));
        inf_sign_d = inf_a ? inSignA : inSignB;
    end

    // Stage 1: magnitude add or subtract; the sign follows the larger magnitude.
    always_comb begin
        sum_d  = '0;
        sign_d = inSignA;
        if (inSignA == inSignB) begin
            sum_d = {1'b0, inAlignedMantissaA} + {1'b0, inAlignedMantissaB};
        end else if (inAlignedMantissaA >= inAlignedMantissaB) begin
            sum_d = {1'b0, inAlignedMantissaA} - {1'b0, inAlignedMantissaB};
        end else begin
            sum_d  = {1'b0, inAlignedMantissaB} - {1'b0, inAlignedMantissaA};
            sign_d = inSignB;
        end
    end

    // Stage 2: normalize and pack. Exponent math is one bit wider than the field.
    logic [EXP_W:0]   e_ext, e_inc, lz_ext, e_sub;
    logic [LZ_W-1:0]  lz;
    logic [MANT_W:0]  shifted;
    always_comb begin
        e_ext    = {1'b0, exp_q};
        e_inc    = e_ext + (EXP_W+1)'(1);
        lz       = lzc(sum_q[MANT_W:0]);
        lz_ext   = {{(EXP_W+1-LZ_W){1'b0}}, lz};
        e_sub    = e_ext - lz_ext;
        shifted  = '0;
        result_d = '0;
        ovf_d    = 1'b0;
        if (special_q) begin
            result_d = is_nan_q ? QNAN : {inf_sign_q, EXP_ONES, {MANT_W{1'b0}}};
        end else if (sum_q == '0) begin
            result_d = {zero_neg_q, {(EXP_W+MANT_W){1'b0}}};
        end else if (sum_q[MANT_W+1]) begin
            if (e_inc >= {1'b0, EXP_ONES}) begin
                result_d = {sign_q, EXP_ONES, {MANT_W{1'b0}}};
                ovf_d    = 1'b1;
            end else begin
                result_d = {sign_q, e_inc[EXP_W-1:0], sum_q[MANT_W:1]};
            end
        end else if (exp_q == '0) begin
            // Subnormal pair: a carry into the hidden position yields exponent 1.
            result_d = {sign_q, {(EXP_W-1){1'b0}}, sum_q[MANT_W], sum_q[MANT_W-1:0]};
        end else if (lz_ext < e_ext) begin
            shifted  = sum_q[MANT_W:0] << lz;
            result_d = {sign_q, e_sub[EXP_W-1:0], shifted[MANT_W-1:0]};
        end else begin
            // Shift only as far as the exponent allows; the result stays subnormal.
            shifted  = sum_q[MANT_W:0] << (e_ext - (EXP_W+1)'(1));
            result_d = {sign_q, {EXP_W{1'b0}}, shifted[MANT_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            sign_q     <= 1'b0;
            zero_neg_q <= 1'b0;
            exp_q      <= '0;
            special_q  <= 1'b0;
            is_nan_q   <= 1'b0;
            inf_sign_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (s1_advance) begin
                s1_valid_q <= inValid;
                if (inValid) begin
                    sum_q      <= sum_d;
                    sign_q     <= sign_d;
                    zero_neg_q <= inSignA && inSignB;
                    exp_q      <= inExponent;
                    special_q  <= spec_a || spec_b;
                    is_nan_q   <= is_nan_d;
                    inf_sign_q <= inf_sign_d;
                end
            end
            if (s2_advance) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    result_q <= result_d;
                    ovf_q    <= ovf_d;
                end
            end
        end
    end

endmodule
